// File: rtl/flip_flop_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flip_flop_pkg
// Description : Shared constants for the flip_flop register slice: default
//               data width and default reset value.
// Revision    : 1.0 - initial release
// ============================================================================
package flip_flop_pkg;

  // Default data width of the register.
  localparam int FF_DEFAULT_WIDTH = 8;

  // Default reset value; widened to the instance width at the top level.
  localparam int FF_DEFAULT_RESET_VALUE = 0;

endpackage : flip_flop_pkg
`default_nettype wire

// File: rtl/flip_flop_bit.sv
`default_nettype none
// ============================================================================
// Module      : flip_flop_bit
// Description : 1-bit D storage cell with synchronous active-high reset and a
//               per-instance reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module flip_flop_bit #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic q_d;
  logic q_q;

  // Next-state data: the cell captures d whenever it is not being reset.
  always_comb begin
    q_d = d;
  end

  // Storage element; reset only acts at the rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= RESET_BIT;
    end else begin
      q_q <= q_d;
    end
  end

  // Output comes straight from the storage element, no logic after it.
  assign q = q_q;

endmodule : flip_flop_bit
`default_nettype wire

// File: rtl/flip_flop.sv
`default_nettype none
// ============================================================================
// Module      : flip_flop
// Description : WIDTH-bit register with synchronous active-high reset to a
//               configurable RESET_VALUE. Built from WIDTH 1-bit cells that
//               all capture on the same rising clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module flip_flop
  import flip_flop_pkg::*;
#(
  parameter int               WIDTH       = FF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(FF_DEFAULT_RESET_VALUE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reject a degenerate register at elaboration time.
  if (WIDTH < 1) begin : g_width_check
    $error("flip_flop: WIDTH must be at least 1");
  end

  // One storage cell per bit; each takes its own bit of the reset value.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bits
    flip_flop_bit #(
      .RESET_BIT (RESET_VALUE[i])
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .d     (d[i]),
      .q     (q[i])
    );
  end

endmodule : flip_flop
`default_nettype wire

// File: tb/tb_flip_flop.sv
`default_nettype none
// ============================================================================
// Module      : tb_flip_flop
// Description : Self-checking bench for flip_flop at default parameters and
//               at WIDTH=16 / RESET_VALUE=0xA5A5, directed then random.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flip_flop;

  localparam logic [7:0]  RV8  = 8'h00;
  localparam logic [15:0] RV16 = 16'hA5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  d8 = 8'h00;
  logic [15:0] d16 = 16'h0000;
  logic [7:0]  q8;
  logic [15:0] q16;

  // Reference state: what q must show after the most recent rising edge.
  logic [7:0]  exp8;
  logic [15:0] exp16;

  int n_vec = 0;
  int n_err = 0;

  flip_flop u_dut8 (
    .clk   (clk),
    .reset (reset),
    .d     (d8),
    .q     (q8)
  );

  flip_flop #(
    .WIDTH       (16),
    .RESET_VALUE (16'hA5A5)
  ) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .d     (d16),
    .q     (q16)
  );

  // 40 ns period, rising edges at 20, 60, 100 ... ns.
  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called 1 ns after a rising edge. Glitches the inputs mid-cycle, settles
  // them 10 ns before the next edge, and checks that q holds until that edge
  // and then shows the value the register rules dictate.
  task automatic apply(input logic r, input logic [7:0] v8, input logic [15:0] v16);
    #9;
    reset = 1'($urandom);
    d8    = 8'($urandom);
    d16   = 16'($urandom);
    #14;
    check("hold8_fall",  {8'h00, q8}, {8'h00, exp8});
    check("hold16_fall", q16, exp16);
    #6;
    reset = r;
    d8    = v8;
    d16   = v16;
    #5;
    check("hold8_pre",  {8'h00, q8}, {8'h00, exp8});
    check("hold16_pre", q16, exp16);
    @(posedge clk);
    #1;
    exp8  = r ? RV8  : v8;
    exp16 = r ? RV16 : v16;
    check("edge8",  {8'h00, q8}, {8'h00, exp8});
    check("edge16", q16, exp16);
  endtask

  initial begin
    logic [7:0] pat [4];
    pat[0] = 8'h01; pat[1] = 8'h80; pat[2] = 8'hAA; pat[3] = 8'h55;

    // Test 1: reset held with d=0x38 over two edges.
    reset = 1'b1;
    d8    = 8'h38;
    d16   = 16'h3838;
    @(posedge clk);
    #1;
    exp8  = RV8;
    exp16 = RV16;
    check("reset8_first",  {8'h00, q8}, {8'h00, exp8});
    check("reset16_first", q16, exp16);
    apply(1'b1, 8'h38, 16'h3838);

    // Test 2: release reset, no recovery cycle.
    apply(1'b0, 8'h38, 16'h3838);

    // Test 3: reset raised 10 ns before an edge.
    apply(1'b1, 8'h38, 16'h3838);

    // Test 4: reload 0x38, then change d 10 ns before an edge.
    apply(1'b0, 8'h38, 16'h3838);
    apply(1'b0, 8'hF0, 16'hF0F0);

    // Test 5: reset priority over simultaneous d change.
    apply(1'b1, 8'hFF, 16'hFFFF);

    // Test 6: walking patterns, each appears one edge later.
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, pat[i], {~pat[i], pat[i]});
    end
    apply(1'b1, 8'h5A, 16'h5A5A);

    // Random traffic with occasional resets.
    for (int i = 0; i < 60; i++) begin
      apply(($urandom_range(0, 7) == 0), 8'($urandom), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000 ns");
    $fatal(1, "timeout");
  end

endmodule : tb_flip_flop
`default_nettype wire

// File: doc/flip_flop.md
FLIP_FLOP -- requirements
Module: flip_flop

Interface
REQ-001 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-002 Parameter WIDTH, default 8, SHALL set the data width of d and q.
REQ-003 Parameter RESET_VALUE, default all-zeros (WIDTH bits), SHALL be the value loaded into q on reset.
REQ-004 Port clk, input, 1 bit, SHALL be the clock; all state changes occur on its rising edge.
REQ-005 Port reset, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-006 Port d, input, WIDTH bits, SHALL be the data to capture.
REQ-007 Port q, output, WIDTH bits, SHALL be the registered data output.
REQ-008 The block SHALL have no ports other than clk, reset, d and q.

Function
REQ-009 At each rising clk edge with reset=1, q SHALL take RESET_VALUE.
REQ-010 At each rising clk edge with reset=0, q SHALL take the value d had at that edge.
REQ-011 Latency SHALL be exactly one clock: d sampled at edge N appears on q immediately after edge N.
REQ-012 Between rising edges, q SHALL hold its value regardless of activity on d or reset.
REQ-013 Asserting reset between edges SHALL NOT change q until the next rising edge.
REQ-014 Changing d between edges SHALL NOT change q until the next rising edge.
REQ-015 When reset=1 and d changes at the same edge, reset SHALL take priority; q = RESET_VALUE.
REQ-016 There SHALL be no combinational path from d or reset to q; q SHALL be driven directly by storage elements.
REQ-017 All WIDTH bits SHALL be captured on the same edge; there are no per-bit enables.
REQ-018 The falling clk edge SHALL have no effect.

Reset
REQ-019 Reset SHALL act only on the rising clk edge; it has no asynchronous term and no sensitivity to the reset signal.
REQ-020 After reset, q SHALL be RESET_VALUE (0x00 at defaults).
REQ-021 Before the first rising edge, q SHALL be undefined; users SHALL hold reset=1 for at least one rising edge before relying on q.
REQ-022 Deasserting reset SHALL make the next rising edge load d; there SHALL be no recovery cycle.

Structure
REQ-023 The default WIDTH (8) and default RESET_VALUE (0) SHALL be defined as constants in the shared project package. flip_flop SHALL reference those constants.
REQ-024 One sub-module, flip_flop_bit, SHALL be used: a 1-bit synchronous-reset D cell with a per-bit reset value.
REQ-025 flip_flop SHALL instantiate WIDTH copies of flip_flop_bit through a generate loop. Each copy SHALL receive bit i of d and bit i of RESET_VALUE.
REQ-026 Parameter checks SHALL reject WIDTH < 1 at elaboration.

Verification (clk period 40 ns, rising edges at 20, 60, 100 ... ns)
REQ-027 Test 1: hold reset=1 and d=0x38 for two rising edges; q SHALL be 0x00.
REQ-028 Test 2: release reset to 0 with d=0x38; after the next rising edge, q SHALL be 0x38.
REQ-029 Test 3: with q=0x38, raise reset 10 ns before a rising edge; q SHALL stay 0x38 until that edge, then become 0x00.
REQ-030 Test 4: with q=0x38 and reset=0, change d to 0xF0 10 ns before a rising edge; q SHALL remain 0x38 before the edge and become 0xF0 after it.
REQ-031 Test 5: at the same edge, set reset=1 and d=0xFF; q SHALL be 0x00, confirming reset priority.
REQ-032 Test 6: with reset=0, drive 0x01, 0x80, 0xAA, 0x55 on consecutive edges; q SHALL follow one edge later each time. The test SHALL be repeated with WIDTH=16 and RESET_VALUE=0xA5A5, where reset SHALL give q=0xA5A5.
